// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
//
// Sends one byte to the device using the inhibit / request-to-send sequence.
// The device then clocks out the start, data, parity and stop bits, and the
// host checks for the device ACK. Both pads are driven open-drain through
// active-high pull-low enables. The parent ties each pad to 1'bz unless the
// matching enable is set.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   PS2_clk      pad level of the PS/2 clock line
//   PS2_data     pad level of the PS/2 data line
//   tx_data      byte to send, sampled only when a transfer is accepted
//   tx_valid     send request; accepted when tx_valid && tx_ready
//   tx_ready     high only while idle
//   ps2_clk_oe   1 = pull PS2_clk low
//   ps2_data_oe  1 = pull PS2_data low
//   busy         high in every state except idle
//   done         1-cycle pulse: device ACKed and both lines returned high
//   error        1-cycle pulse: missing ACK or timeout
module ps2_host_tx #(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned INHIBIT_CYCLES = 12_000,
  parameter int unsigned RTS_CYCLES     = 16,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       PS2_clk,
  input  logic       PS2_data,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned InhW  = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned RtsW  = (RTS_CYCLES > 1) ? $clog2(RTS_CYCLES) : 1;
  localparam int unsigned FiltW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES + 1);

  // CLK_HZ only documents the intended clock; reject a nonsensical value.
  if (CLK_HZ == 0) begin : g_bad_clk_hz
    $error("CLK_HZ must be nonzero");
  end

  typedef enum logic [2:0] {
    StIdle, StInhibit, StRts, StSend, StAckChk, StWaitIdle
  } state_e;

  // Input conditioning; index 0 = clock line, index 1 = data line.
  logic [1:0]       r_sync1, r_sync2, r_filt;
  logic [FiltW-1:0] r_fcnt [2];
  logic             r_clk_prev;
  logic             w_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 2'b11;
      r_sync2    <= 2'b11;
      r_filt     <= 2'b11;
      r_fcnt[0]  <= '0;
      r_fcnt[1]  <= '0;
      r_clk_prev <= 1'b1;
    end else begin
      r_sync1    <= {PS2_data, PS2_clk};
      r_sync2    <= r_sync1;
      r_clk_prev <= r_filt[0];
      for (int i = 0; i < 2; i++) begin
        // Count consecutive samples that disagree with the filtered level;
        // flip the level once FILTER_LEN of them have been seen.
        if (r_sync2[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FiltW'(FILTER_LEN - 1)) begin
          r_filt[i] <= r_sync2[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + FiltW'(1);
        end
      end
    end
  end

  assign w_fall = r_clk_prev & ~r_filt[0];

  // Transmit FSM and datapath.
  state_e          r_state, w_state_nxt;
  logic            r_clk_oe, w_clk_oe_nxt;
  logic            r_data_oe, w_data_oe_nxt;
  logic            r_busy;
  logic [9:0]      r_shift, w_shift_nxt;   // {stop, parity, d7..d0}; start is implicit
  logic [3:0]      r_bit_cnt, w_bit_nxt;
  logic [InhW-1:0] r_inh_cnt, w_inh_nxt;
  logic [RtsW-1:0] r_rts_cnt, w_rts_nxt;
  logic [ToW-1:0]  r_to_cnt, w_to_nxt;
  logic            w_timeout;

  assign w_timeout = (r_to_cnt == ToW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_busy    <= 1'b0;
      r_shift   <= '1;
      r_bit_cnt <= '0;
      r_inh_cnt <= '0;
      r_rts_cnt <= '0;
      r_to_cnt  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clk_oe  <= w_clk_oe_nxt;
      r_data_oe <= w_data_oe_nxt;
      r_busy    <= (w_state_nxt != StIdle);
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_inh_cnt <= w_inh_nxt;
      r_rts_cnt <= w_rts_nxt;
      r_to_cnt  <= w_to_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clk_oe_nxt  = r_clk_oe;
    w_data_oe_nxt = r_data_oe;
    w_shift_nxt   = r_shift;
    w_bit_nxt     = r_bit_cnt;
    w_inh_nxt     = r_inh_cnt;
    w_rts_nxt     = r_rts_cnt;
    w_to_nxt      = r_to_cnt;
    done          = 1'b0;
    error         = 1'b0;

    // Saturating timeout counter, live only while the device owns the clock.
    if ((r_state == StSend || r_state == StWaitIdle) && !w_timeout) begin
      w_to_nxt = r_to_cnt + ToW'(1);
    end

    unique case (r_state)
      StIdle: begin
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
        if (tx_valid) begin
          w_state_nxt  = StInhibit;
          w_clk_oe_nxt = 1'b1;
          w_shift_nxt  = {1'b1, ~^tx_data, tx_data};
          w_inh_nxt    = '0;
        end
      end
      StInhibit: begin
        if (r_inh_cnt == InhW'(INHIBIT_CYCLES - 1)) begin
          w_state_nxt   = StRts;
          w_data_oe_nxt = 1'b1;             // start bit
          w_rts_nxt     = '0;
        end else begin
          w_inh_nxt = r_inh_cnt + InhW'(1);
        end
      end
      StRts: begin
        if (r_rts_cnt == RtsW'(RTS_CYCLES - 1)) begin
          w_state_nxt  = StSend;
          w_clk_oe_nxt = 1'b0;
          w_to_nxt     = '0;
          w_bit_nxt    = '0;
        end else begin
          w_rts_nxt = r_rts_cnt + RtsW'(1);
        end
      end
      StSend: begin
        if (w_timeout) begin
          error         = 1'b1;
          w_state_nxt   = StIdle;
          w_clk_oe_nxt  = 1'b0;
          w_data_oe_nxt = 1'b0;
        end else if (w_fall) begin
          if (r_bit_cnt != 4'hF) w_bit_nxt = r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd10) begin
            w_state_nxt = StAckChk;            // edge 11: device drives ACK
          end else begin
            w_data_oe_nxt = ~r_shift[0];
            w_shift_nxt   = {1'b1, r_shift[9:1]};
          end
        end
      end
      StAckChk: begin
        if (r_filt[1]) begin
          error       = 1'b1;
          w_state_nxt = StIdle;
        end else begin
          w_state_nxt = StWaitIdle;
        end
      end
      StWaitIdle: begin
        if (r_filt == 2'b11) begin
          done        = 1'b1;
          w_state_nxt = StIdle;
        end else if (w_timeout) begin
          error         = 1'b1;
          w_state_nxt   = StIdle;
          w_clk_oe_nxt  = 1'b0;
          w_data_oe_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt   = StIdle;
        w_clk_oe_nxt  = 1'b0;
        w_data_oe_nxt = 1'b0;
      end
    endcase
  end

  assign tx_ready    = (r_state == StIdle);
  assign busy        = r_busy;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, error;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_line, ps2_data_line;

  // Open-drain lines with pull-ups: low if either side pulls.
  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(20),
    .RTS_CYCLES    (4),
    .FILTER_LEN    (4),
    .TIMEOUT_CYCLES(5000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PS2_clk    (ps2_clk_line),
    .PS2_data   (ps2_data_line),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Pulse monitor.
  int   cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, err_cyc = 0, coe_fall_cyc = 0;
  logic prev_coe = 1'b0;
  always @(negedge clk) begin
    cyc      <= cyc + 1;
    prev_coe <= ps2_clk_oe;
    if (prev_coe && !ps2_clk_oe) coe_fall_cyc <= cyc;
    if (done) done_cnt <= done_cnt + 1;
    if (error) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (done && error) both_cnt <= both_cnt + 1;
  end

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  // Device model, 40-cycle clock period. Measures the inhibit and RTS phases,
  // then clocks 11 falling edges, sampling the data line while the clock is
  // high just before each fall; optionally pulls data low for the ACK.
  task automatic run_device(input logic give_ack, output logic [10:0] bits,
                            output int inh, output int rts, output logic stuck);
    inh   = 0;
    rts   = 0;
    stuck = 1'b1;
    bits  = '0;
    for (int g = 0; g < 200; g++) begin
      @(negedge clk);
      if (ps2_clk_oe && !ps2_data_oe) inh++;
      else if (ps2_clk_oe && ps2_data_oe) rts++;
      else begin
        stuck = 1'b0;
        break;
      end
    end
    repeat (20) @(negedge clk);
    for (int k = 0; k < 11; k++) begin
      repeat (10) @(negedge clk);
      bits[k] = ps2_data_line;
      if (k == 10 && give_ack) dev_data_low = 1'b1;
      repeat (10) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b0;
    end
    dev_data_low = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (ps2_clk_oe !== 1'b0) begin n_bad++; $display("FAIL reset_clk_oe got %b want 0", ps2_clk_oe); end
    n_cmp++; if (ps2_data_oe !== 1'b0) begin n_bad++; $display("FAIL reset_data_oe got %b want 0", ps2_data_oe); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error got %b want 0", error); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", tx_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_send_ed;
    logic [10:0] bits;
    int inh, rts, d0, e0;
    logic stuck;
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hED);
    n_cmp++; if (busy !== 1'b1 || ps2_clk_oe !== 1'b1) begin
      n_bad++; $display("FAIL ed_accept got busy=%b clk_oe=%b want 1 1", busy, ps2_clk_oe); end
    run_device(1'b1, bits, inh, rts, stuck);
    repeat (30) @(negedge clk);
    n_cmp++; if (stuck !== 1'b0) begin n_bad++; $display("FAIL ed_release got stuck=%b want 0", stuck); end
    n_cmp++; if (inh != 20) begin n_bad++; $display("FAIL ed_inhibit_len got %0d want 20", inh); end
    n_cmp++; if (rts != 4) begin n_bad++; $display("FAIL ed_rts_len got %0d want 4", rts); end
    n_cmp++; if (bits !== 11'h7DA) begin n_bad++; $display("FAIL ed_bits got %h want 7da", bits); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL ed_done got %0d want 1", done_cnt - d0); end
    n_cmp++; if (err_cnt - e0 != 0) begin n_bad++; $display("FAIL ed_error got %0d want 0", err_cnt - e0); end
    n_cmp++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL ed_idle got ready=%b busy=%b want 1 0", tx_ready, busy); end
  endtask

  task automatic test_send_zero;
    logic [10:0] bits;
    int inh, rts, d0, e0;
    logic stuck;
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h00);
    run_device(1'b1, bits, inh, rts, stuck);
    repeat (30) @(negedge clk);
    n_cmp++; if (bits !== 11'h600) begin n_bad++; $display("FAIL zero_bits got %h want 600", bits); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL zero_done got %0d want 1", done_cnt - d0); end
    n_cmp++; if (err_cnt - e0 != 0) begin n_bad++; $display("FAIL zero_error got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_missing_ack;
    logic [10:0] bits;
    int inh, rts, d0, e0;
    logic stuck;
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hFF);
    run_device(1'b0, bits, inh, rts, stuck);
    repeat (30) @(negedge clk);
    n_cmp++; if (bits !== 11'h7FE) begin n_bad++; $display("FAIL nack_bits got %h want 7fe", bits); end
    n_cmp++; if (err_cnt - e0 != 1) begin n_bad++; $display("FAIL nack_error got %0d want 1", err_cnt - e0); end
    n_cmp++; if (done_cnt - d0 != 0) begin n_bad++; $display("FAIL nack_done got %0d want 0", done_cnt - d0); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL nack_ready got %b want 1", tx_ready); end
  endtask

  task automatic test_timeout;
    int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hF4);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!ps2_clk_oe) break;
    end
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (err_cnt != e0) break;
    end
    repeat (2) @(negedge clk);
    n_cmp++; if (err_cnt - e0 != 1) begin n_bad++; $display("FAIL to_error got %0d want 1", err_cnt - e0); end
    n_cmp++; if (err_cyc - coe_fall_cyc != 5000) begin
      n_bad++; $display("FAIL to_delay got %0d want 5000", err_cyc - coe_fall_cyc); end
    n_cmp++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      n_bad++; $display("FAIL to_release got clk_oe=%b data_oe=%b want 0 0", ps2_clk_oe, ps2_data_oe); end
    n_cmp++; if (done_cnt - d0 != 0) begin n_bad++; $display("FAIL to_done got %0d want 0", done_cnt - d0); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL to_ready got %b want 1", tx_ready); end
  endtask

  task automatic test_busy;
    logic [10:0] bits;
    int inh, rts, d0, e0;
    logic stuck, ready_seen;
    d0 = done_cnt; e0 = err_cnt;
    ready_seen = 1'b1;
    start_tx(8'hED);
    fork
      run_device(1'b1, bits, inh, rts, stuck);
      begin
        repeat (60) @(negedge clk);
        tx_data    = 8'hAA;
        tx_valid   = 1'b1;
        ready_seen = tx_ready;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    repeat (30) @(negedge clk);
    n_cmp++; if (ready_seen !== 1'b0) begin n_bad++; $display("FAIL busy_ready got %b want 0", ready_seen); end
    n_cmp++; if (bits !== 11'h7DA) begin n_bad++; $display("FAIL busy_bits got %h want 7da", bits); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_bad++; $display("FAIL busy_done got %0d want 1", done_cnt - d0); end
    n_cmp++; if (err_cnt - e0 != 0) begin n_bad++; $display("FAIL busy_error got %0d want 0", err_cnt - e0); end
    repeat (50) @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || ps2_clk_oe !== 1'b0) begin
      n_bad++; $display("FAIL busy_no_requeue got busy=%b clk_oe=%b want 0 0", busy, ps2_clk_oe); end
  endtask

  task automatic test_mid_reset;
    start_tx(8'h3C);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!ps2_clk_oe) break;
    end
    repeat (50) @(negedge clk);
    n_cmp++; if (ps2_data_oe !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL mid_pre got data_oe=%b busy=%b want 1 1", ps2_data_oe, busy); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      n_bad++; $display("FAIL mid_release got clk_oe=%b data_oe=%b want 0 0", ps2_clk_oe, ps2_data_oe); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready got %b want 1", tx_ready); end
    repeat (20) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_send_zero();
    test_missing_ack();
    test_timeout();
    test_busy();
    test_mid_reset();
    n_cmp++; if (both_cnt != 0) begin n_bad++; $display("FAIL done_error_overlap got %0d want 0", both_cnt); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device transmitter for the PS/2 port. It sends one command byte to the keyboard, such as 0xED (set LEDs), 0xFF (reset) or 0xF4 (enable), using the standard request-to-send / device-clocked / ACK sequence. It sits beside the keyboard receiver on the same PS2_clk/PS2_data pads. It drives both lines open-drain through active-high pull-low enables. Top ties each pad to 1'bz unless the matching enable is set.

## Interface
- CLK_HZ, 100_000_000: system clock frequency; documentation only, not used in logic.
- INHIBIT_CYCLES, 12_000: cycles PS2_clk is held low before request-to-send (120 µs at 100 MHz).
- RTS_CYCLES, 16: cycles both lines are held low before the clock is released.
- FILTER_LEN, 4: consecutive identical synchronized samples needed to change a filtered line level.
- TIMEOUT_CYCLES, 2_000_000: maximum cycles from clock release to ACK sample (20 ms).
---
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- PS2_clk  in  1  pad level of the PS/2 clock line.
- PS2_data  in  1  pad level of the PS/2 data line.
- tx_data  in  8  byte to send; sampled only at accept.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE; a transfer is accepted when tx_valid && tx_ready.
- ps2_clk_oe  out  1  1 = pull PS2_clk low.
- ps2_data_oe  out  1  1 = pull PS2_data low.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the device ACKs and both lines have returned high.
- error  out  1  one-cycle pulse on a missing ACK or a timeout.

## Operation
- **Input conditioning.** PS2_clk and PS2_data each pass through a 2-flop synchronizer, then a FILTER_LEN-sample level filter. The filtered clock has a 1-cycle-delayed copy. A falling edge is defined as previous = 1 and current = 0.
- **Frame.** The frame is 11 bits: start (0), d0..d7 LSB first, parity, stop (1).
  - Parity is odd: parity = ~^tx_data.
  - The frame is latched into a shift register at accept.
- **IDLE.** tx_ready = 1. Both oe outputs = 0. Edges on the lines are ignored.
- **INHIBIT.** On accept, enter INHIBIT. ps2_clk_oe = 1 and ps2_data_oe = 0 for INHIBIT_CYCLES cycles.
- **RTS.** ps2_clk_oe = 1 and ps2_data_oe = 1 (start bit) for RTS_CYCLES cycles.
- **SEND.** ps2_clk_oe = 0. The timeout counter is cleared. A 4-bit bit counter starts at 0.
  - On each filtered falling edge, ps2_data_oe <= ~(next frame bit) and the bit counter increments.
  - Edges 1..8 put out d0..d7. Edge 9 puts out parity. Edge 10 puts out the stop bit, which sets ps2_data_oe = 0 (line released).
  - On edge 11, go to ACK_CHK.
- **ACK_CHK.** Sample filtered PS2_data in this single cycle.
  - 0: go to WAIT_IDLE.
  - 1: pulse error and go to IDLE.
- **WAIT_IDLE.** Wait until filtered PS2_clk and PS2_data are both 1, then pulse done and go to IDLE.
- **Timeout.** The counter runs in SEND and WAIT_IDLE. If it reaches TIMEOUT_CYCLES:
  - release both lines;
  - pulse error;
  - go to IDLE;
  - discard the frame.
- **Counter widths.** Each counter is sized by $clog2 of its own parameter and saturates at its terminal count. None wraps.

## Timing
- **Reset values.** ps2_clk_oe = 0, ps2_data_oe = 0, busy = 0, done = 0, error = 0, tx_ready = 1, state = IDLE. Reset is effective immediately and asynchronously, including mid-frame, so the lines are released at once.
- **Registered outputs.** busy and both oe outputs are registered. ps2_clk_oe rises on the clock edge after accept.
- **Phase lengths.** ps2_clk_oe stays high for exactly INHIBIT_CYCLES + RTS_CYCLES cycles. ps2_data_oe goes high exactly INHIBIT_CYCLES cycles after ps2_clk_oe.
- **Edge latency.**
  - Pad falling edge to filtered edge: 2 + FILTER_LEN cycles.
  - Filtered edge to updated ps2_data_oe: 1 cycle.
  - Total: 7 cycles with defaults, far inside the device's low half-period (≥30 µs).
- **Pulses.** done and error are each exactly 1 cycle and never assert together. tx_ready returns high on the cycle after the pulse.
- **tx_valid while busy.** Ignored, with no queueing. tx_data changes after accept do not affect the frame.
- **Edges outside SEND.** Device clock edges during INHIBIT/RTS are ignored. Edges after edge 11 in WAIT_IDLE are ignored.

## Test plan
Bench parameters: INHIBIT_CYCLES = 20, RTS_CYCLES = 4, TIMEOUT_CYCLES = 5000. Device model period 40 cycles.
- **Reset.** Assert rst_n = 0 mid-SEND → both oe = 0, busy = 0 in the same cycle. After release, tx_ready = 1.
- **Send 0xED, device ACKs.** The model samples at rising edges and must see 0, 1,0,1,1,0,1,1,1, parity 1, stop 1. It pulls data low for bit 11 → one done pulse, no error. INHIBIT and RTS lengths are 20 and 4 cycles.
- **Send 0x00.** Sampled bits: start 0, eight 0s, parity 1, stop 1 → done.
- **Missing ACK.** Send 0xFF (parity 1); the model leaves data high at bit 11 → one error pulse, no done, return to IDLE.
- **Timeout.** Send 0xF4; the model never clocks → error exactly 5000 cycles after ps2_clk_oe falls, both lines released.
- **Busy.** Pulse tx_valid with 0xAA during a 0xED transfer → ignored; only 0xED bits appear and exactly one done pulse occurs.
